tt_mem_bridge: RTL and testbench

- Byte-wide host bridge between the 8-bit TinyTapeout pin interface and a word-wide synchronous RAM (instruction or program memory).
- Load path packs host bytes into WORD_W-bit words and writes them to memory.
- Dump path reads a block of words and streams them out byte-serially with a valid/ready handshake.
- Supersedes the fixed 32-bit byte-rotation readout: adds parametrised width/depth, block dumps, backpressure and a cpu_hold ownership signal.

---
 rtl/tt_mem_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_tt_mem_bridge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_mem_bridge.sv
// ============================================================================
// Module   : tt_mem_bridge
// Purpose  : Byte-wide host bridge between the 8-bit TinyTapeout pin
//            interface and a word-wide synchronous RAM. The load path packs
//            host bytes little-endian into WORD_W-bit words and writes them.
//            The dump path reads a block of words and streams them out
//            LSB-first under a valid/ready handshake.
// Ports    : clk, rst_n (synchronous, active low)
//            ld_valid/ld_byte/ld_addr/ld_ready          - byte load channel
//            dump_start/dump_addr/dump_count/dump_busy  - block dump control
//            out_byte/out_valid/out_ready               - byte output stream
//            mem_we/mem_addr/mem_wdata/mem_rdata        - RAM port (1-cycle read)
//            cpu_hold                                   - bridge owns memory
// Options  : TT_MEM_BRIDGE_CHECKSUM_EN - append an 8-bit mod-256 sum of the
//            dumped bytes as one extra output byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_mem_bridge #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_ready,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_addr,
    input  logic [ADDR_W-1:0] dump_count,
    output logic              dump_busy,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              cpu_hold
);

    localparam int c_BYTES  = WORD_W / 8;
    localparam int c_LANE_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_BYTES - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WR    = 3'd1;
    localparam logic [2:0] c_ST_RD    = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_SHIFT = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [c_LANE_W-1:0] r_lane;      // load byte lane
    logic [c_LANE_W-1:0] r_bidx;      // dump byte index within current word
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   r_count;     // words left, including the current one
    logic [WORD_W-1:0]   r_wbuf;      // load word assembly
    logic [WORD_W-1:0]   r_sbuf;      // dump shift buffer

    logic w_ld_fire;
    logic w_dump_go;
    logic w_hs;
    logic w_in_csum;
    logic w_word_done;
    logic w_last_word;

`ifdef TT_MEM_BRIDGE_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_csum_phase;          // presenting the trailing sum byte
    assign w_in_csum = r_csum_phase;
`else
    assign w_in_csum = 1'b0;
`endif

    assign w_ld_fire   = ld_valid && (r_state == c_ST_IDLE);
    // A load byte in the same cycle takes priority over a dump request.
    assign w_dump_go   = dump_start && (r_state == c_ST_IDLE) && (r_lane == '0)
                         && (dump_count != '0) && !ld_valid;
    assign w_hs        = (r_state == c_ST_SHIFT) && out_ready;
    assign w_word_done = w_hs && !w_in_csum && (r_bidx == c_LAST_LANE);
    assign w_last_word = (r_count == ADDR_W'(1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_ld_fire && (r_lane == c_LAST_LANE)) begin
                    w_next_state = c_ST_WR;
                end else if (w_dump_go) begin
                    w_next_state = c_ST_RD;
                end
            end
            c_ST_WR:   w_next_state = c_ST_IDLE;
            c_ST_RD:   w_next_state = c_ST_WAIT;
            c_ST_WAIT: w_next_state = c_ST_SHIFT;
            c_ST_SHIFT: begin
                if (w_hs && w_in_csum) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_word_done) begin
                    if (!w_last_word) begin
                        w_next_state = c_ST_RD;
                    end else begin
`ifdef TT_MEM_BRIDGE_CHECKSUM_EN
                        w_next_state = c_ST_SHIFT;
`else
                        w_next_state = c_ST_IDLE;
`endif
                    end
                end
            end
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane     <= '0;
            r_bidx     <= '0;
            r_mem_addr <= '0;
            r_count    <= '0;
            r_wbuf     <= '0;
            r_sbuf     <= '0;
`ifdef TT_MEM_BRIDGE_CHECKSUM_EN
            r_sum        <= '0;
            r_csum_phase <= 1'b0;
`endif
        end else begin
            if (w_ld_fire) begin
                // Shift in from the top: after BYTES bytes the first byte
                // sits in bits [7:0], giving little-endian packing.
                r_wbuf <= (r_wbuf >> 8) | (WORD_W'(ld_byte) << (WORD_W - 8));
                r_lane <= (r_lane == c_LAST_LANE) ? '0 : r_lane + c_LANE_W'(1);
                if (r_lane == '0) begin
                    r_mem_addr <= ld_addr;
                end
            end

            if (w_dump_go) begin
                r_mem_addr <= dump_addr;
                r_count    <= dump_count;
                r_bidx     <= '0;
`ifdef TT_MEM_BRIDGE_CHECKSUM_EN
                r_sum        <= '0;
                r_csum_phase <= 1'b0;
`endif
            end

            if (r_state == c_ST_WAIT) begin
                r_sbuf <= mem_rdata;
            end

            if (w_hs) begin
`ifdef TT_MEM_BRIDGE_CHECKSUM_EN
                if (r_csum_phase) begin
                    r_csum_phase <= 1'b0;
                end else begin
                    r_sum <= r_sum + r_sbuf[7:0];
                end
`endif
                if (!w_in_csum) begin
                    r_sbuf <= r_sbuf >> 8;
                    if (r_bidx == c_LAST_LANE) begin
                        r_bidx <= '0;
                        if (!w_last_word) begin
                            r_count    <= r_count - ADDR_W'(1);
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        end else begin
`ifdef TT_MEM_BRIDGE_CHECKSUM_EN
                            r_csum_phase <= 1'b1;
`endif
                        end
                    end else begin
                        r_bidx <= r_bidx + c_LANE_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_wbuf;

    always_comb begin
        mem_we    = (r_state == c_ST_WR);
        ld_ready  = (r_state == c_ST_IDLE);
        out_valid = (r_state == c_ST_SHIFT);
        dump_busy = (r_state == c_ST_RD) || (r_state == c_ST_WAIT)
                    || (r_state == c_ST_SHIFT);
        cpu_hold  = (r_state != c_ST_IDLE) || (r_lane != '0);
        out_byte  = 8'h00;
        if (r_state == c_ST_SHIFT) begin
`ifdef TT_MEM_BRIDGE_CHECKSUM_EN
            out_byte = r_csum_phase ? r_sum : r_sbuf[7:0];
`else
            out_byte = r_sbuf[7:0];
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tt_mem_bridge.sv
// ============================================================================
// Module   : tb_tt_mem_bridge
// Purpose  : Self-checking bench for tt_mem_bridge. A RAM model sits on the
//            memory port; a reference copy of memory and a byte queue built
//            from it predict every write and every streamed byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_mem_bridge;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 7;
    localparam int BYTES  = WORD_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_byte = '0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic              ld_ready;
    logic              dump_start = 1'b0;
    logic [ADDR_W-1:0] dump_addr = '0;
    logic [ADDR_W-1:0] dump_count = '0;
    logic              dump_busy;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              cpu_hold;

    always #5 clk = ~clk;

    tt_mem_bridge #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_addr(ld_addr), .ld_ready(ld_ready),
        .dump_start(dump_start), .dump_addr(dump_addr), .dump_count(dump_count),
        .dump_busy(dump_busy),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
    );

    // Synchronous RAM: read data valid one cycle after the address.
    logic [WORD_W-1:0] ram [0:DEPTH-1];
    int wr_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    logic [WORD_W-1:0] ref_mem [0:DEPTH-1];
    logic [7:0] mq [$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected byte stream of a dump, straight from the reference memory.
    task automatic build_model(input int addr, input int count);
        logic [WORD_W-1:0] w;
        logic [7:0] sum;
        mq.delete();
        sum = 8'h00;
        for (int i = 0; i < count; i++) begin
            w = ref_mem[(addr + i) % DEPTH];
            for (int b = 0; b < BYTES; b++) begin
                mq.push_back(w[8*b +: 8]);
                sum = sum + w[8*b +: 8];
            end
        end
`ifdef TT_MEM_BRIDGE_CHECKSUM_EN
        mq.push_back(sum);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ld_valid = 1'b0; dump_start = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_byte", 64'(out_byte), 64'(0));
        check("rst_dump_busy", 64'(dump_busy), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ld_ready", 64'(ld_ready), 64'(1));
    endtask

    task automatic load_word(input int addr, input logic [WORD_W-1:0] word, input bit with_dump);
        int w0;
        int gap;
        w0 = wr_cnt;
        for (int k = 0; k < BYTES; k++) begin
            gap = (k > 0) ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("ld_gap_ready", 64'(ld_ready), 64'(1));
                check("ld_gap_we", 64'(mem_we), 64'(0));
                check("ld_gap_hold", 64'(cpu_hold), 64'(1));
                check("ld_gap_busy", 64'(dump_busy), 64'(0));
                ld_valid = 1'b0;
                dump_start = ($urandom % 2) == 1;   // partial word: must be ignored
                dump_count = ADDR_W'(2);
            end
            @(negedge clk);
            check("ld_ready", 64'(ld_ready), 64'(1));
            check("ld_we_idle", 64'(mem_we), 64'(0));
            check("ld_busy", 64'(dump_busy), 64'(0));
            check("ld_hold", 64'(cpu_hold), 64'(k != 0));
            ld_valid = 1'b1;
            ld_byte = word[8*k +: 8];
            ld_addr = (k == 0) ? ADDR_W'(addr) : ADDR_W'($urandom);
            dump_start = with_dump || ((k > 0) && (($urandom % 2) == 1));
            dump_count = ADDR_W'(2);
        end
        @(negedge clk);
        check("wr_we", 64'(mem_we), 64'(1));
        check("wr_addr", 64'(mem_addr), 64'(addr));
        check("wr_data", 64'(mem_wdata), 64'(word));
        check("wr_ld_ready", 64'(ld_ready), 64'(0));
        check("wr_hold", 64'(cpu_hold), 64'(1));
        check("wr_busy", 64'(dump_busy), 64'(0));
        ld_valid = 1'b0; dump_start = 1'b0;
        @(negedge clk);
        check("post_wr_we", 64'(mem_we), 64'(0));
        check("post_wr_ready", 64'(ld_ready), 64'(1));
        check("post_wr_busy", 64'(dump_busy), 64'(0));
        check("post_wr_hold", 64'(cpu_hold), 64'(0));
        check("wr_count", 64'(wr_cnt - w0), 64'(1));
        ref_mem[addr] = word;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 4 cycles on byte 0x34
    task automatic dump_block(input int addr, input int count, input int mode);
        logic [7:0] q [$];
        int gap, popped, stall_left, cyc, total;
        bit done, rdy, exp_valid;
        build_model(addr, count);
        q = mq;
        total = count * BYTES;
        @(negedge clk);
        check("dmp_pre_ready", 64'(ld_ready), 64'(1));
        check("dmp_pre_busy", 64'(dump_busy), 64'(0));
        dump_start = 1'b1; dump_addr = ADDR_W'(addr); dump_count = ADDR_W'(count);
        ld_valid = 1'b0; out_ready = 1'b0;
        gap = 2; popped = 0; stall_left = 4; cyc = 0; done = 1'b0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            exp_valid = (gap == 0);
            check("dmp_busy", 64'(dump_busy), 64'(1));
            check("dmp_valid", 64'(out_valid), 64'(exp_valid));
            check("dmp_we", 64'(mem_we), 64'(0));
            check("dmp_ld_ready", 64'(ld_ready), 64'(0));
            check("dmp_hold", 64'(cpu_hold), 64'(1));
            if (exp_valid) check("dmp_byte", 64'(out_byte), 64'(q[0]));
            dump_start = ($urandom % 4) == 0;    // ignored while busy
            ld_valid = ($urandom % 2) == 1;      // ignored while busy
            ld_byte = 8'($urandom);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom % 3) != 0;
                default: begin
                    rdy = 1'b1;
                    if (exp_valid && q[0] == 8'h34 && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end
                end
            endcase
            out_ready = rdy;
            if (gap > 0) begin
                gap--;
            end else if (rdy) begin
                void'(q.pop_front());
                popped++;
                if (q.size() == 0) done = 1'b1;
                else if ((popped % BYTES) == 0 && popped < total) gap = 2;
            end
        end
        if (!done) check("dmp_timeout", 64'(0), 64'(1));
        if (mode == 2) check("dmp_stalls_used", 64'(stall_left), 64'(0));
        @(negedge clk);
        check("dmp_end_busy", 64'(dump_busy), 64'(0));
        check("dmp_end_valid", 64'(out_valid), 64'(0));
        check("dmp_end_hold", 64'(cpu_hold), 64'(0));
        check("dmp_end_ready", 64'(ld_ready), 64'(1));
        ld_valid = 1'b0; out_ready = 1'b0; dump_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pin [8];
        int w0;
        pin = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hD4, 8'hC3, 8'hB2, 8'hA1};

        do_reset();

        // Fill the whole memory through the load path.
        for (int a = 0; a < DEPTH; a++) load_word(a, WORD_W'($urandom), 1'b0);

        load_word(5, 32'h12345678, 1'b0);
        load_word(6, 32'hA1B2C3D4, 1'b0);

        build_model(5, 2);
        for (int i = 0; i < 8; i++) check("pin_model_byte", 64'(mq[i]), 64'(pin[i]));

        dump_block(5, 2, 0);
        dump_block(5, 2, 2);

        // Address wrap at the top of memory.
        load_word(127, 32'hDEAD0127, 1'b0);
        load_word(0, 32'hBEEF0000, 1'b0);
        dump_block(127, 2, 1);

        // Reset mid-load after two bytes.
        @(negedge clk);
        ld_valid = 1'b1; ld_byte = 8'hEE; ld_addr = ADDR_W'(9);
        @(negedge clk);
        ld_byte = 8'hDD;
        @(negedge clk);
        check("mid_ld_hold", 64'(cpu_hold), 64'(1));
        ld_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("mid_ld_rst_hold", 64'(cpu_hold), 64'(0));
        check("mid_ld_rst_we", 64'(mem_we), 64'(0));
        rst_n = 1'b1;
        w0 = wr_cnt;
        load_word(3, 32'hCAFEF00D, 1'b0);
        check("mid_ld_one_write", 64'(wr_cnt - w0), 64'(1));

        // Reset mid-dump while streaming.
        @(negedge clk);
        dump_start = 1'b1; dump_addr = ADDR_W'(5); dump_count = ADDR_W'(2); out_ready = 1'b0;
        @(negedge clk);
        dump_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_dmp_valid", 64'(out_valid), 64'(1));
        check("mid_dmp_byte", 64'(out_byte), 64'(8'h78));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_dmp_rst_valid", 64'(out_valid), 64'(0));
        check("mid_dmp_rst_busy", 64'(dump_busy), 64'(0));
        check("mid_dmp_rst_hold", 64'(cpu_hold), 64'(0));
        rst_n = 1'b1;

        // Load byte and dump request together: load wins.
        load_word(9, 32'h0BADBEEF, 1'b1);

        // Zero-count dump is a no-op.
        @(negedge clk);
        dump_start = 1'b1; dump_addr = ADDR_W'(1); dump_count = '0;
        @(negedge clk);
        dump_start = 1'b0;
        check("zero_busy", 64'(dump_busy), 64'(0));
        check("zero_hold", 64'(cpu_hold), 64'(0));
        @(negedge clk);
        check("zero_busy2", 64'(dump_busy), 64'(0));
        check("zero_valid", 64'(out_valid), 64'(0));

        // Randomized mix.
        for (int it = 0; it < 40; it++) begin
            if (($urandom % 2) == 1)
                load_word($urandom_range(0, DEPTH - 1), WORD_W'($urandom), ($urandom % 2) == 1);
            else
                dump_block($urandom_range(0, DEPTH - 1), $urandom_range(1, 4), $urandom_range(0, 1));
        end
        dump_block($urandom_range(0, DEPTH - 1), 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
